axi_ram_slave: RTL and testbench

AXI3 slave responder backed by an internal byte-writable synchronous RAM. It answers the read and write bursts issued by the CPU-side AXI master (cpu_axi_interface / system cache path). It serves as the memory model at the far end of the bus in simulation and as small on-chip RAM in FPGA builds. It supports one outstanding transaction at a time and INCR bursts of 1..16 beats of 32 bits.

---
 rtl/axi_ram_slave_pkg.sv | 11 +
 rtl/axi_ram_slave_if.sv | 41 ++++
 rtl/axi_ram_slave_ram_bytewr.sv | 21 ++
 rtl/axi_ram_slave.sv | 115 +++++++++++
 tb/tb_axi_ram_slave.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_ram_slave_pkg.sv
// axi_ram_slave_pkg: shared AXI constants, field widths and FSM encodings
package axi_ram_slave_pkg;
    localparam int ID_W  = 4;
    localparam int LEN_W = 4;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;
endpackage

// File: rtl/axi_ram_slave_if.sv
// axi_ram_slave_if: AXI3 read/write channel bundle with master and slave views
interface axi_ram_slave_if;
    import axi_ram_slave_pkg::*;
    logic [ID_W-1:0]  arid;
    logic [31:0]      araddr;
    logic [LEN_W-1:0] arlen;
    logic             arvalid;
    logic             arready;
    logic [ID_W-1:0]  rid;
    logic [31:0]      rdata;
    logic [1:0]       rresp;
    logic             rlast;
    logic             rvalid;
    logic             rready;
    logic [ID_W-1:0]  awid;
    logic [31:0]      awaddr;
    logic [LEN_W-1:0] awlen;
    logic             awvalid;
    logic             awready;
    logic [31:0]      wdata;
    logic [3:0]       wstrb;
    logic             wlast;
    logic             wvalid;
    logic             wready;
    logic [ID_W-1:0]  bid;
    logic [1:0]       bresp;
    logic             bvalid;
    logic             bready;
    modport slave (
        input  arid, araddr, arlen, arvalid, rready,
        input  awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
        output arready, rid, rdata, rresp, rlast, rvalid,
        output awready, wready, bid, bresp, bvalid
    );
    modport master (
        output arid, araddr, arlen, arvalid, rready,
        output awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
        input  arready, rid, rdata, rresp, rlast, rvalid,
        input  awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/axi_ram_slave_ram_bytewr.sv
// ram_bytewr: single-port 32-bit synchronous RAM with byte write enables and registered read
module ram_bytewr #(
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [MEM_AW-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    logic [31:0] mem [2**MEM_AW];
    // byte-lane writes and a read that only updates when enabled, so stalled data stays put
    always_ff @(posedge clk) begin
        if (we[0]) mem[addr][7:0]   <= wdata[7:0];
        if (we[1]) mem[addr][15:8]  <= wdata[15:8];
        if (we[2]) mem[addr][23:16] <= wdata[23:16];
        if (we[3]) mem[addr][31:24] <= wdata[31:24];
        if (en) rdata <= mem[addr];
    end
endmodule

// File: rtl/axi_ram_slave.sv
// axi_ram_slave: single-outstanding AXI3 INCR burst responder in front of a byte-writable RAM
module axi_ram_slave
    import axi_ram_slave_pkg::*;
#(
    parameter int MEM_AW    = 10,
    parameter bit INIT_ZERO = 1'b0
) (
    input logic             aclk,
    input logic             aresetn,
    axi_ram_slave_if.slave  axi
);
    logic [1:0]        state;
    logic [ID_W-1:0]   rid_q;
    logic [ID_W-1:0]   bid_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt;
    logic [MEM_AW-1:0] addr_q;
    logic [MEM_AW-1:0] ar_word;
    logic [MEM_AW-1:0] aw_word;
    logic [MEM_AW-1:0] ram_addr;
    logic [3:0]        ram_we;
    logic [31:0]       ram_q;
    logic              ram_en;
    logic              idle;
    logic              rd_st;
    logic              wr_st;
    logic              wb_st;
    logic              w_end;
    logic              unused_bits;

    // the RAM powers up undefined; INIT_ZERO is kept only for build compatibility
    assign unused_bits = ^{axi.araddr[31:MEM_AW+2], axi.araddr[1:0],
                           axi.awaddr[31:MEM_AW+2], axi.awaddr[1:0], INIT_ZERO};

    assign ar_word = axi.araddr[MEM_AW+1:2];
    assign aw_word = axi.awaddr[MEM_AW+1:2];
    assign idle    = aresetn && state == S_IDLE;
    assign rd_st   = aresetn && state == S_RD;
    assign wr_st   = aresetn && state == S_WR;
    assign wb_st   = aresetn && state == S_WB;
    assign w_end   = axi.wlast || cnt == len_q;

    assign axi.arready = idle;
    assign axi.awready = idle && !axi.arvalid;
    assign axi.wready  = wr_st;
    assign axi.rvalid  = rd_st;
    assign axi.rlast   = rd_st && cnt == len_q;
    assign axi.rdata   = rd_st ? ram_q : '0;
    assign axi.rid     = aresetn ? rid_q : '0;
    assign axi.rresp   = RESP_OKAY;
    assign axi.bvalid  = wb_st;
    assign axi.bid     = aresetn ? bid_q : '0;
    assign axi.bresp   = RESP_OKAY;

    // first beat is fetched at the AR handshake, later beats on each accepted non-final R beat
    assign ram_en   = (idle && axi.arvalid) || (rd_st && axi.rready && !axi.rlast);
    assign ram_addr = idle ? ar_word : addr_q;
    assign ram_we   = (wr_st && axi.wvalid) ? axi.wstrb : 4'b0000;

    ram_bytewr #(.MEM_AW(MEM_AW)) u_ram (
        .clk   (aclk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (axi.wdata),
        .rdata (ram_q)
    );

    // transaction FSM: addr_q runs one word ahead during reads and tracks the current word during writes
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state  <= S_IDLE;
            rid_q  <= '0;
            bid_q  <= '0;
            len_q  <= '0;
            cnt    <= '0;
            addr_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (axi.arvalid) begin
                        rid_q  <= axi.arid;
                        len_q  <= axi.arlen;
                        cnt    <= '0;
                        addr_q <= ar_word + 1'b1;
                        state  <= S_RD;
                    end else if (axi.awvalid) begin
                        bid_q  <= axi.awid;
                        len_q  <= axi.awlen;
                        cnt    <= '0;
                        addr_q <= aw_word;
                        state  <= S_WR;
                    end
                end
                S_RD: begin
                    if (axi.rready) begin
                        cnt    <= cnt + 1'b1;
                        addr_q <= addr_q + 1'b1;
                        if (axi.rlast) state <= S_IDLE;
                    end
                end
                S_WR: begin
                    if (axi.wvalid) begin
                        cnt    <= cnt + 1'b1;
                        addr_q <= addr_q + 1'b1;
                        if (w_end) state <= S_WB;
                    end
                end
                default: begin
                    if (axi.bready) state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_ram_slave.sv
// tb_axi_ram_slave: directed vectors, corner sequences and randomized bursts against a word-array memory model
module tb_axi_ram_slave;
    import axi_ram_slave_pkg::*;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axi_ram_slave_if bus ();

    axi_ram_slave #(.MEM_AW(10), .INIT_ZERO(1'b0)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .axi     (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] mdat [1024];
    logic [3:0]  mkn  [1024];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] last_rd;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;
    vec_t vt [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] k);
        return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
    endfunction

    function automatic logic sel_sig(input int s);
        return s == 0 ? bus.arready : s == 1 ? bus.awready : s == 2 ? bus.wready : bus.bvalid;
    endfunction

    // wait (bounded) for the selected ready/valid, then step through the handshake edge
    task automatic wait_hs(input int sel, input string nm);
        int n;
        for (n = 0; n < 64; n++) begin
            #1;
            if (sel_sig(sel)) break;
            tick();
        end
        checks++;
        if (n == 64) begin
            errors++;
            $display("FAIL %s timeout actual=0 expected=1", nm);
        end
        tick();
    endtask

    function automatic void mwrite(input int w, input logic [31:0] d, input logic [3:0] s);
        for (int i = 0; i < 4; i++)
            if (s[i]) begin
                mdat[w][8*i +: 8] = d[8*i +: 8];
                mkn[w][i] = 1'b1;
            end
    endfunction

    task automatic aw_phase(input logic [31:0] addr, input int len, input logic [3:0] id);
        bus.awaddr = addr;
        bus.awlen = 4'(len);
        bus.awid = id;
        bus.awvalid = 1'b1;
        wait_hs(1, "aw_hs");
        bus.awvalid = 1'b0;
    endtask

    task automatic w_b_phase(input int word, input int len, input int wlb, input logic [3:0] id);
        int nb;
        nb = (wlb < len ? wlb : len) + 1;
        for (int b = 0; b < nb; b++) begin
            bus.wvalid = 1'b1;
            bus.wdata = wd[b];
            bus.wstrb = ws[b];
            bus.wlast = (b == wlb);
            wait_hs(2, "w_hs");
            mwrite((word + b) % 1024, wd[b], ws[b]);
        end
        bus.wvalid = 1'b0;
        bus.wlast = 1'b0;
        #1;
        chk("bvalid", bus.bvalid, 1);
        chk("no_extra_w", bus.wready, 0);
        chk("bid", bus.bid, id);
        chk("bresp", bus.bresp, 0);
        repeat ($urandom % 3) begin
            tick();
            #1;
            chk("bvalid_hold", bus.bvalid, 1);
        end
        bus.bready = 1'b1;
        wait_hs(3, "b_hs");
        bus.bready = 1'b0;
    endtask

    task automatic ar_phase(input logic [31:0] addr, input int len, input logic [3:0] id);
        bus.araddr = addr;
        bus.arlen = 4'(len);
        bus.arid = id;
        bus.arvalid = 1'b1;
        wait_hs(0, "ar_hs");
        bus.arvalid = 1'b0;
    endtask

    // collect R beats and compare each against the model; stalled beats must not change
    task automatic r_phase(input int word, input int len, input logic [3:0] id, input bit rnd);
        int b = 0;
        int cyc;
        bit st = 1'b0;
        logic [31:0] pd;
        logic pl;
        logic [31:0] m;
        for (cyc = 0; cyc < 400 && b <= len; cyc++) begin
            bus.rready = rnd ? 1'($urandom % 2) : 1'b1;
            #1;
            if (cyc == 0) chk("rvalid_first", bus.rvalid, 1);
            if (bus.rvalid) chk("awready_in_rd", bus.awready, 0);
            if (st && bus.rvalid) begin
                chk("rdata_hold", bus.rdata, pd);
                chk("rlast_hold", bus.rlast, pl);
            end
            if (bus.rvalid && bus.rready) begin
                m = bmask(mkn[(word + b) % 1024]);
                chk("rdata", bus.rdata & m, mdat[(word + b) % 1024] & m);
                chk("rlast", bus.rlast, b == len);
                chk("rid", bus.rid, id);
                chk("rresp", bus.rresp, 0);
                last_rd = bus.rdata;
                b++;
                st = 1'b0;
            end else if (bus.rvalid) begin
                st = 1'b1;
                pd = bus.rdata;
                pl = bus.rlast;
            end
            tick();
        end
        bus.rready = 1'b0;
        chk("r_beats", b, len + 1);
        if (!rnd) chk("r_cycles", cyc, len + 1);
        #1;
        chk("arready_after_r", bus.arready, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        int word, len, wlb, nb;
        logic [31:0] addr;
        logic [3:0] id;
        for (int i = 0; i < 1024; i++) mkn[i] = 4'b0000;
        bus.arvalid = 0; bus.araddr = 0; bus.arlen = 0; bus.arid = 0; bus.rready = 0;
        bus.awvalid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awid = 0;
        bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
        vt[0] = '{32'h10,   32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
        vt[1] = '{32'h10,   32'h11223344, 4'h5, 32'hDE22BE44};
        vt[2] = '{32'h13,   32'hAABBCCDD, 4'h8, 32'hAA22BE44};
        vt[3] = '{32'h1010, 32'h00000000, 4'h0, 32'hAA22BE44};
        vt[4] = '{32'h20,   32'h12345678, 4'hF, 32'h12345678};

        repeat (3) tick();
        chk("rst_arready", bus.arready, 0);
        chk("rst_awready", bus.awready, 0);
        chk("rst_wready", bus.wready, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_bvalid", bus.bvalid, 0);
        chk("rst_rlast", bus.rlast, 0);
        chk("rst_rid", bus.rid, 0);
        chk("rst_bid", bus.bid, 0);
        chk("rst_rdata", bus.rdata, 0);
        aresetn = 1'b1;
        #1;
        chk("idle_arready", bus.arready, 1);
        chk("idle_awready", bus.awready, 1);
        chk("idle_wready", bus.wready, 0);
        tick();

        // single-beat write/read vectors: full word, byte strobes, ignored address bits
        for (int i = 0; i < 5; i++) begin
            word = (vt[i].addr >> 2) & 1023;
            wd[0] = vt[i].wdata;
            ws[0] = vt[i].strb;
            aw_phase(vt[i].addr, 0, 4'(i + 1));
            w_b_phase(word, 0, 0, 4'(i + 1));
            ar_phase(vt[i].addr, 0, 4'(i + 9));
            r_phase(word, 0, 4'(i + 9), 1'b0);
            chk("vec_rdata", last_rd, vt[i].exp);
        end

        // 16-beat burst, then read back with rready held and with rready toggling
        for (int b = 0; b < 16; b++) begin
            wd[b] = b;
            ws[b] = 4'hF;
        end
        aw_phase(32'h100, 15, 4'h3);
        w_b_phase(32'h40, 15, 15, 4'h3);
        ar_phase(32'h100, 15, 4'h6);
        r_phase(32'h40, 15, 4'h6, 1'b0);
        chk("burst_last", last_rd, 15);
        ar_phase(32'h100, 15, 4'h7);
        r_phase(32'h40, 15, 4'h7, 1'b1);

        // simultaneous AR and AW: read wins, write waits for the rlast handshake
        bus.awaddr = 32'h40; bus.awlen = 0; bus.awid = 4'hA; bus.awvalid = 1'b1;
        bus.araddr = 32'h100; bus.arlen = 3; bus.arid = 4'hB; bus.arvalid = 1'b1;
        #1;
        chk("coll_arready", bus.arready, 1);
        chk("coll_awready", bus.awready, 0);
        wait_hs(0, "coll_ar_hs");
        bus.arvalid = 1'b0;
        r_phase(32'h40, 3, 4'hB, 1'b0);
        wd[0] = 32'hCAFEF00D;
        ws[0] = 4'hF;
        wait_hs(1, "coll_aw_hs");
        bus.awvalid = 1'b0;
        w_b_phase(32'h10, 0, 0, 4'hA);
        ar_phase(32'h40, 0, 4'h1);
        r_phase(32'h10, 0, 4'h1, 1'b0);
        chk("coll_mem", last_rd, 32'hCAFEF00D);

        // word index wraps at the top of memory
        wd[0] = 32'hAAAA0001; wd[1] = 32'hBBBB0002;
        ws[0] = 4'hF; ws[1] = 4'hF;
        aw_phase(32'hFFC, 1, 4'h2);
        w_b_phase(1023, 1, 1, 4'h2);
        ar_phase(32'hFFC, 0, 4'h4);
        r_phase(1023, 0, 4'h4, 1'b0);
        chk("wrap_a", last_rd, 32'hAAAA0001);
        ar_phase(32'h000, 0, 4'h5);
        r_phase(0, 0, 4'h5, 1'b0);
        chk("wrap_b", last_rd, 32'hBBBB0002);

        // reset in the middle of a read burst abandons it; memory survives
        ar_phase(32'h100, 15, 4'h8);
        bus.rready = 1'b1;
        tick();
        tick();
        aresetn = 1'b0;
        bus.rready = 1'b0;
        #1;
        chk("midrst_rvalid_low", bus.rvalid, 0);
        tick();
        aresetn = 1'b1;
        #1;
        chk("postrst_rvalid", bus.rvalid, 0);
        chk("postrst_arready", bus.arready, 1);
        tick();
        ar_phase(32'hFFC, 0, 4'h9);
        r_phase(1023, 0, 4'h9, 1'b0);
        chk("postrst_mem", last_rd, 32'hAAAA0001);

        // randomized bursts with early/late wlast and random stalls
        for (int it = 0; it < 20; it++) begin
            addr = $urandom;
            word = (addr >> 2) & 1023;
            len = $urandom % 16;
            id = 4'($urandom);
            for (int b = 0; b < 16; b++) begin
                wd[b] = $urandom;
                ws[b] = 4'($urandom);
            end
            wlb = ($urandom % 4 == 0) ? ($urandom % 16) : len;
            nb = (wlb < len ? wlb : len) + 1;
            aw_phase(addr, len, id);
            w_b_phase(word, len, wlb, id);
            ar_phase(addr, nb - 1, ~id);
            r_phase(word, nb - 1, ~id, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
